// File: rtl/shift_piso_arbiter_if.sv
// Request-side and serial-side signal bundle for the shared PISO shifter.
// The slave modport is the arbiter's view; master is the producer/link side.
interface shift_piso_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 4
);
   localparam int OWN_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]        req_vld;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ack;
   logic                      ser_ready;
   logic                      ser_vld;
   logic                      ser_dout;
   logic                      ser_first;
   logic                      ser_last;
   logic [OWN_W-1:0]          ser_owner;

   modport slave (
      input  req_vld,
      input  req_data,
      input  ser_ready,
      output req_ack,
      output ser_vld,
      output ser_dout,
      output ser_first,
      output ser_last,
      output ser_owner
   );

   modport master (
      output req_vld,
      output req_data,
      output ser_ready,
      input  req_ack,
      input  ser_vld,
      input  ser_dout,
      input  ser_first,
      input  ser_last,
      input  ser_owner
   );
endinterface

// File: rtl/shift_piso_arbiter.sv
// Round-robin arbiter feeding one shared parallel-in/serial-out shifter.
// Words are serialised MSB first, followed by GAP_CYC idle cycles per frame.
module shift_piso_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 4,
   parameter int GAP_CYC = 1
) (
   input  logic                 shift_reg_clk,
   input  logic                 shift_reg_rst,
   shift_piso_arbiter_if.slave  bus,
   output logic                 busy
);
   localparam int OWN_W = $clog2(NUM_REQ);
   localparam int BIT_W = $clog2(DATA_W);
   localparam int GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
   localparam logic [BIT_W-1:0] BIT_TOP = BIT_W'(DATA_W - 1);
   localparam logic [GAP_W-1:0] GAP_TOP = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
   localparam logic [OWN_W-1:0] OWN_TOP = OWN_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t            r_state;
   logic [DATA_W-1:0] r_sreg;
   logic [BIT_W-1:0]  r_bit_cnt;
   logic [GAP_W-1:0]  r_gap_cnt;
   logic [OWN_W-1:0]  r_ptr;
   logic [OWN_W-1:0]  r_owner;

   state_t            w_state_next;
   logic [DATA_W-1:0] w_sreg_next;
   logic [BIT_W-1:0]  w_bit_cnt_next;
   logic [GAP_W-1:0]  w_gap_cnt_next;
   logic [OWN_W-1:0]  w_ptr_next;
   logic [OWN_W-1:0]  w_owner_next;

   logic [DATA_W-1:0] w_word [NUM_REQ];
   logic              w_gnt_found;
   logic [OWN_W-1:0]  w_gnt_idx;
   logic [NUM_REQ-1:0] w_ack;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign w_word[gi] = bus.req_data[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // Search starts at the round-robin pointer and wraps; first valid wins.
   always_comb begin
      int               idx;
      logic [OWN_W-1:0] cand;
      w_gnt_found = 1'b0;
      w_gnt_idx   = '0;
      idx         = 0;
      cand        = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(r_ptr) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         cand = OWN_W'(idx);
         if (!w_gnt_found && bus.req_vld[cand]) begin
            w_gnt_found = 1'b1;
            w_gnt_idx   = cand;
         end
      end
   end

   always_comb begin
      w_ack = '0;
      if (r_state == ST_IDLE && w_gnt_found) begin
         w_ack[w_gnt_idx] = 1'b1;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_sreg_next    = r_sreg;
      w_bit_cnt_next = r_bit_cnt;
      w_gap_cnt_next = r_gap_cnt;
      w_ptr_next     = r_ptr;
      w_owner_next   = r_owner;
      case (r_state)
         ST_IDLE: begin
            if (w_gnt_found) begin
               w_sreg_next    = w_word[w_gnt_idx];
               w_owner_next   = w_gnt_idx;
               w_ptr_next     = (w_gnt_idx == OWN_TOP) ? '0 : w_gnt_idx + 1'b1;
               w_bit_cnt_next = BIT_TOP;
               w_state_next   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            // A deasserted ser_ready freezes the frame in place for any length.
            if (bus.ser_ready) begin
               w_sreg_next = {r_sreg[DATA_W-2:0], 1'b0};
               if (r_bit_cnt == '0) begin
                  if (GAP_CYC > 0) begin
                     w_state_next   = ST_GAP;
                     w_gap_cnt_next = GAP_TOP;
                  end else begin
                     w_state_next = ST_IDLE;
                  end
               end else begin
                  w_bit_cnt_next = r_bit_cnt - 1'b1;
               end
            end
         end
         ST_GAP: begin
            if (r_gap_cnt == '0) begin
               w_state_next = ST_IDLE;
            end else begin
               w_gap_cnt_next = r_gap_cnt - 1'b1;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge shift_reg_clk) begin
      if (shift_reg_rst) begin
         r_state   <= ST_IDLE;
         r_sreg    <= '0;
         r_bit_cnt <= '0;
         r_gap_cnt <= '0;
         r_ptr     <= '0;
         r_owner   <= '0;
      end else begin
         r_state   <= w_state_next;
         r_sreg    <= w_sreg_next;
         r_bit_cnt <= w_bit_cnt_next;
         r_gap_cnt <= w_gap_cnt_next;
         r_ptr     <= w_ptr_next;
         r_owner   <= w_owner_next;
      end
   end

   assign bus.req_ack   = w_ack;
   assign bus.ser_vld   = (r_state == ST_SHIFT);
   assign bus.ser_dout  = (r_state == ST_SHIFT) & r_sreg[DATA_W-1];
   assign bus.ser_first = (r_state == ST_SHIFT) & (r_bit_cnt == BIT_TOP);
   assign bus.ser_last  = (r_state == ST_SHIFT) & (r_bit_cnt == '0);
   assign bus.ser_owner = r_owner;
   assign busy          = (r_state != ST_IDLE);
endmodule

// File: doc/shift_piso_arbiter.md
Name: shift_piso_arbiter

Overview:
- Round-robin controller that shares one parallel-in/serial-out shifter among NUM_REQ requesters.
- Accepts one parallel word per grant over a valid/ack handshake, then serialises it MSB first on a single-bit stream with a downstream ready.
- Inserts a programmable idle gap between frames.
- Sits between parallel-word producers and a serial link in the shift-register datapath.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_W, 4, bits per word/frame (>=2)
GAP_CYC, 1, idle cycles after each frame (>=0)

Ports:
shift_reg_clk  input  1  clock, all logic on rising edge
shift_reg_rst  input  1  synchronous active-high reset
req_vld  input  NUM_REQ  per-requester word valid (level)
req_data  input  NUM_REQ*DATA_W  requester i word at [i*DATA_W +: DATA_W]
req_ack  output  NUM_REQ  one-hot grant; transfer when req_vld[i] & req_ack[i] at clock edge
ser_ready  input  1  downstream accepts current bit
ser_vld  output  1  ser_dout valid
ser_dout  output  1  serial data, MSB first
ser_first  output  1  current bit is bit DATA_W-1 of frame
ser_last  output  1  current bit is bit 0 of frame
ser_owner  output  $clog2(NUM_REQ)  index of requester owning current/last frame
busy  output  1  state != IDLE

Behaviour:
- One clock (shift_reg_clk); reset is synchronous and active-high (shift_reg_rst). Reset values: state IDLE, shift reg 0, bit_cnt 0, gap_cnt 0, rr ptr 0, ser_owner 0. Outputs at reset: ser_vld 0, ser_dout 0, ser_first 0, ser_last 0, busy 0, req_ack 0.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - req_ack is combinational: one-hot on the first requester with req_vld=1, searching ptr, ptr+1, ... wrapping mod NUM_REQ. It is 0 if no req_vld or state != IDLE.
  - On the edge with grant g: sreg <= word g, owner <= g, ptr <= (g+1) mod NUM_REQ, bit_cnt <= DATA_W-1, state <= SHIFT.
  - Latency: first serial bit is valid the cycle after the ack.
- SHIFT:
  - ser_vld=1, ser_dout=sreg[DATA_W-1], ser_first=(bit_cnt==DATA_W-1), ser_last=(bit_cnt==0).
  - On ser_ready=1: sreg <= sreg<<1 and bit_cnt--. At bit_cnt==0 go to GAP (GAP_CYC>0, gap_cnt <= GAP_CYC-1) or IDLE (GAP_CYC==0).
  - On ser_ready=0: all state and outputs hold. Stall duration is unbounded; no bit is lost or duplicated.
- GAP: ser_vld=0, ser_dout=0. Decrement gap_cnt; at 0 go to IDLE.
- ser_dout, ser_first, ser_last are 0 whenever ser_vld=0.
- ser_owner holds its value until the next grant.
- Requests arriving during SHIFT/GAP wait (no ack). Arbitration occurs in the first IDLE cycle.
- Back-to-back frames: one IDLE cycle, then DATA_W SHIFT cycles (no stall), then GAP_CYC cycles. Period is 1+DATA_W+GAP_CYC.
- A requester may drop req_vld before ack with no effect. After ack, a requester must drop req_vld or present its next word; req_data is sampled only on the ack edge.
- Reset mid-frame: next cycle IDLE, ser_vld 0, ptr 0. The partial frame is discarded and never resumed.
- Counter widths: bit_cnt $clog2(DATA_W); gap_cnt $clog2(GAP_CYC+1), minimum 1 bit.

Test Plan:
- Reset, then req_vld=4'b0010 with word1=4'b1101, ser_ready=1 -> req_ack=4'b0010 for 1 cycle. ser_dout 1,1,0,1 on 4 consecutive cycles; ser_first on bit 1 only, ser_last on bit 4 only; ser_owner=1; then 1 cycle ser_vld=0; busy high 5 cycles.
- All four req_vld held high, words 0x1/0x2/0x4/0x8 -> grants in order 0,1,2,3,0, one ack every 6 cycles; each frame carries the correct word.
- Word 4'b1010, ser_ready low 2 cycles while bit 2 is presented -> ser_dout=0 and ser_vld=1 held 3 cycles. Accepted stream is 1,0,1,0; frame lengthens by 2 cycles.
- Reset asserted after 2 bits of a frame -> next cycle ser_vld=0, busy=0. Then req_vld=4'b0101 -> requester 0 granted (ptr=0).
- req_vld[3] raised during requester 0's SHIFT -> no ack until the GAP ends; ack[3] in the first IDLE cycle.
- req_vld[2] pulsed for 1 cycle during SHIFT only -> no ack and no frame for requester 2.
